// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC / BTB slice.
// Latency: none (package only: constants, types, pure functions).
// Backpressure: none.
package pc_pkg;

    // 2-bit saturating counter: MSB is the taken prediction.
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_INIT  = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Status part of a BTB entry. Tag and target are kept in separate
    // arrays beside it because their widths depend on module parameters.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_btb_array.sv
// Direct-mapped BTB: combinational lookup, registered training update.
// Latency: lookup 0 cycles; update visible next cycle (same cycle with PC_BTB_FWD_EN).
// Backpressure: none; updates are always accepted, including during stall/redirect.
// Ports: clk/rst (async active-high); lookup_pc -> pred_taken/pred_target;
//        upd_valid/upd_pc/upd_target/upd_taken train the entry indexed by upd_pc.
// Optional macro PC_BTB_FWD_EN forwards a same-index update into the lookup.
module pc_btb_array
    import pc_pkg::*;
#(
    parameter int XLEN      = 16,
    parameter int BTB_DEPTH = 8,
    parameter int IDX_LSB   = 0,
    parameter int INC       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_LSB - IDX_W;
    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    btb_entry_t       ent_q [BTB_DEPTH];
    logic [TAG_W-1:0] tag_q [BTB_DEPTH];
    logic [XLEN-1:0]  tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0] u_idx, l_idx;
    logic [TAG_W-1:0] u_tag, l_tag;
    logic             u_hit;

    // Post-update image of the entry at u_idx, plus its write enable.
    btb_entry_t       w_ent;
    logic [TAG_W-1:0] w_tag;
    logic [XLEN-1:0]  w_tgt;
    logic             w_en;

    btb_entry_t       r_ent;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_tgt;
    logic             l_hit;

    assign u_idx = upd_pc[IDX_LSB +: IDX_W];
    assign u_tag = upd_pc[XLEN-1 -: TAG_W];
    assign l_idx = lookup_pc[IDX_LSB +: IDX_W];
    assign l_tag = lookup_pc[XLEN-1 -: TAG_W];

    // Tag/target of an invalid entry may be uninitialised; valid gates them.
    assign u_hit = ent_q[u_idx].valid && (tag_q[u_idx] == u_tag);

    always_comb begin
        w_ent = ent_q[u_idx];
        w_tag = tag_q[u_idx];
        w_tgt = tgt_q[u_idx];
        w_en  = 1'b0;
        if ((upd_valid == 1'b1) && (rst == 1'b0)) begin
            if (u_hit) begin
                w_en      = 1'b1;
                w_ent.ctr = upd_taken ? ctr_inc(ent_q[u_idx].ctr) : ctr_dec(ent_q[u_idx].ctr);
                if (upd_taken) begin
                    w_tgt = upd_target;
                end
            end else if (upd_taken) begin
                // Miss + taken replaces whatever lived at this index.
                w_en        = 1'b1;
                w_ent.valid = 1'b1;
                w_ent.ctr   = CTR_ALLOC;
                w_tag       = u_tag;
                w_tgt       = upd_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                ent_q[i].valid <= 1'b0;
                ent_q[i].ctr   <= CTR_INIT;
            end
        end else if (w_en) begin
            ent_q[u_idx] <= w_ent;
        end
    end

    // Tags and targets need no reset: they are only observed behind valid.
    always_ff @(posedge clk) begin
        if (w_en) begin
            tag_q[u_idx] <= w_tag;
            tgt_q[u_idx] <= w_tgt;
        end
    end

    always_comb begin
        r_ent = ent_q[l_idx];
        r_tag = tag_q[l_idx];
        r_tgt = tgt_q[l_idx];
`ifdef PC_BTB_FWD_EN
        if (w_en && (u_idx == l_idx)) begin
            r_ent = w_ent;
            r_tag = w_tag;
            r_tgt = w_tgt;
        end
`endif
    end

    assign l_hit       = r_ent.valid && (r_tag == l_tag);
    assign pred_taken  = l_hit && r_ent.ctr[1];
    assign pred_target = pred_taken ? r_tgt : lookup_pc + INC_V;

endmodule

// File: rtl/pc_btb_unit.sv
// Fetch PC register with BTB-based next-PC prediction.
// Latency: next PC appears on pc one cycle after the edge; redirect costs 1 cycle.
// Backpressure: stall holds pc; redirect overrides stall; BTB training never blocks.
// Ports: clk, rst (async active-high), stall, redirect_valid/redirect_pc,
//        upd_valid/upd_pc/upd_target/upd_taken (BTB training from EX),
//        pc (registered), pred_taken/pred_target (combinational from pc).
// Optional macro PC_BTB_FWD_EN: same-cycle BTB update forwarded to the lookup.
module pc_btb_unit
    import pc_pkg::*;
#(
    parameter int XLEN      = 16,
    parameter int BTB_DEPTH = 8,
    parameter int IDX_LSB   = 0,
    parameter int INC       = 1,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam logic [XLEN-1:0] RESET_PC_V = XLEN'(RESET_PC);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;

    pc_btb_array #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH),
        .IDX_LSB   (IDX_LSB),
        .INC       (INC)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always_comb begin
        pc_nxt = pred_target;
        if (redirect_valid == 1'b1) begin
            pc_nxt = redirect_pc;
        end else if (stall == 1'b1) begin
            pc_nxt = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC_V;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_btb_unit.sv
// Directed bench for pc_btb_unit with default parameters.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: exercises stall, redirect and their interaction with training.
module tb_pc_btb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;

    int n_cmp = 0;
    int n_err = 0;

    pc_btb_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [15:0] p, input logic [15:0] t, input logic tk);
        upd_valid  = 1'b1;
        upd_pc     = p;
        upd_target = t;
        upd_taken  = tk;
    endtask

    task automatic redir(input logic [15:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
    endtask

    task automatic idle();
        upd_valid      = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

        // 1. reset state, then free-running fetch
        #2;
        chk("rst_pc", pc, 0);
        chk("rst_ptk", pred_taken, 0);
        chk("rst_ptgt", pred_target, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", pc, i);
            chk("seq_ptk", pred_taken, 0);
        end

        // 2. train 0x3 taken, then walk the counter down
        upd(16'h0003, 16'h0040, 1'b1); step();
        chk("tr_pc5", pc, 16'h0005);
        idle(); redir(16'h0003); step(); idle();
        chk("tr_ptk", pred_taken, 1);
        chk("tr_ptgt", pred_target, 16'h0040);
        step();
        chk("tr_jump", pc, 16'h0040);
        upd(16'h0003, 16'h0040, 1'b0); redir(16'h0003); step(); redirect_valid = 1'b0;
        chk("dec1_pc", pc, 16'h0003);
        chk("dec1_ptk", pred_taken, 0);
        chk("dec1_ptgt", pred_target, 16'h0004);
        step();
        chk("dec2_pc", pc, 16'h0004);
        redir(16'h0003); step(); redirect_valid = 1'b0;
        chk("sat_lo_ptk", pred_taken, 0);
        upd(16'h0003, 16'h0040, 1'b1); step(); idle();
        chk("inc01_pc", pc, 16'h0004);
        redir(16'h0003); step(); idle();
        chk("inc01_ptk", pred_taken, 0);
        upd(16'h0003, 16'h0040, 1'b1); stall = 1'b1; step(); idle();
        chk("stall_upd_pc", pc, 16'h0003);
        chk("stall_upd_ptk", pred_taken, 1);

        // 3. redirect beats stall, then stall holds
        stall = 1'b1; redir(16'h0100); step(); redirect_valid = 1'b0;
        chk("redir_stall", pc, 16'h0100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", pc, 16'h0100);
        end
        idle();

        // 4. aliasing: 0xB replaces 0x3 at index 3
        upd(16'h0003, 16'h0040, 1'b1); step();
        upd(16'h000B, 16'h0080, 1'b1); step(); idle();
        redir(16'h0003); step(); idle();
        chk("alias3_ptk", pred_taken, 0);
        chk("alias3_ptgt", pred_target, 16'h0004);
        redir(16'h000B); step(); idle();
        chk("aliasB_ptk", pred_taken, 1);
        chk("aliasB_ptgt", pred_target, 16'h0080);
        step();
        chk("aliasB_pc", pc, 16'h0080);

        // 5. wrap at top of address space
        redir(16'hFFFF); step(); idle();
        chk("wrap_ptgt", pred_target, 16'h0000);
        step();
        chk("wrap_pc", pc, 16'h0000);

        // 6. asynchronous reset mid-cycle, mid-stall
        upd(16'h0003, 16'h0040, 1'b1); step(); idle();
        chk("pre_rst_pc", pc, 16'h0001);
        stall = 1'b1; redir(16'h0200);
        #2; rst = 1'b1; #1;
        chk("arst_pc", pc, 0);
        chk("arst_ptk", pred_taken, 0);
        chk("arst_ptgt", pred_target, 16'h0001);
        step();
        chk("arst_hold_pc", pc, 0);
        rst = 1'b0; idle();
        redir(16'h0003); step(); idle();
        chk("post_rst_ptk", pred_taken, 0);
        chk("post_rst_ptgt", pred_target, 16'h0004);

        // same-cycle update at the current pc
        upd(16'h0003, 16'h0050, 1'b1); #1;
`ifdef PC_BTB_FWD_EN
        chk("fwd_ptk", pred_taken, 1);
        chk("fwd_ptgt", pred_target, 16'h0050);
        step(); idle();
        chk("fwd_pc", pc, 16'h0050);
`else
        chk("nofwd_ptk", pred_taken, 0);
        chk("nofwd_ptgt", pred_target, 16'h0004);
        step(); idle();
        chk("nofwd_pc", pc, 16'h0004);
`endif
        redir(16'h0003); step(); idle();
        chk("late_ptk", pred_taken, 1);
        chk("late_ptgt", pred_target, 16'h0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
